// File: rtl/game_pkg.sv
// Shared encodings for the Frogger round sequencer, timer and renderer.
package game_pkg;

    typedef enum logic [1:0] {
        GS_TITLE = 2'b00,
        GS_PLAY  = 2'b01,
        GS_OVER  = 2'b10,
        GS_CLEAR = 2'b11
    } game_state_e;

    typedef enum logic [2:0] {
        ST_TITLE,
        ST_PLAY,
        ST_DEATH,
        ST_CLEAR,
        ST_OVER
    } fsm_state_e;

    localparam int SCORE_W     = 16;
    localparam int LEVEL_W     = 4;
    localparam int FRAME_CNT_W = 8;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

    // The death animation is still "play" as far as the timer and renderer care.
    function automatic game_state_e to_game_state(input fsm_state_e s);
        case (s)
            ST_PLAY, ST_DEATH: return GS_PLAY;
            ST_CLEAR:          return GS_CLEAR;
            ST_OVER:           return GS_OVER;
            default:           return GS_TITLE;
        endcase
    endfunction

endpackage

// File: rtl/frame_delay_counter.sv
// Frame-paced delay counter shared by the death and level-clear sequences.
module frame_delay_counter
    import game_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   clr,
    input  logic                   frame_en,
    input  logic [FRAME_CNT_W-1:0] len,
    output logic                   done
);

    logic [FRAME_CNT_W-1:0] count_q;
    logic [FRAME_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (frame_en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Fires on the frame edge that completes the len-th frame.
    assign done = frame_en && !clr && (count_q == FRAME_CNT_W'(len - 1'b1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Frogger round sequencer: turns raw game events into the frame-paced
// title/play/death/clear/over flow, and owns lives, homes, level and score.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int                   START_LIVES    = 3,
    parameter int                   HOMES_TO_CLEAR = 5,
    parameter logic [7:0]           DEATH_FRAMES   = 8'd90,
    parameter logic [7:0]           CLEAR_FRAMES   = 8'd120,
    parameter logic [SCORE_W-1:0]   HOME_POINTS    = 16'd50
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk_rising_edge,
    input  logic                start_key,
    input  logic                frog_hit,
    input  logic                frog_home,
    input  logic [7:0]          TimeLeft,
    output logic [1:0]          GameState,
    output logic                TimerReset,
    output logic                is_dead_delayed,
    output logic                frog_freeze,
    output logic [1:0]          Lives,
    output logic [2:0]          HomesFilled,
    output logic [LEVEL_W-1:0]  Level,
    output logic [SCORE_W-1:0]  Score
);

    fsm_state_e           state_q, state_d;
    logic [1:0]           lives_q, lives_d;
    logic [2:0]           homes_q, homes_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 timer_reset_q, timer_reset_d;
    logic                 dead_q, dead_d;
    logic                 start_prev_q;

    logic                 start_edge;
    logic                 time_out;
    logic                 in_delay;
    logic                 delay_done;
    logic [2:0]           homes_inc;
    logic [SCORE_W:0]     score_sum;

    assign start_edge = start_key && !start_prev_q;
    // The timer needs a cycle to reload after TimerReset, so a zero right then is stale.
    assign time_out   = (TimeLeft == 8'd0) && !timer_reset_q;
    assign in_delay   = (state_q == ST_DEATH) || (state_q == ST_CLEAR);
    assign homes_inc  = homes_q + 3'd1;
    assign score_sum  = {1'b0, score_q} + {1'b0, HOME_POINTS} + (SCORE_W+1)'(TimeLeft);

    frame_delay_counter u_delay (
        .Clk      (Clk),
        .Reset    (Reset),
        .clr      (!in_delay),
        .frame_en (in_delay && frame_clk_rising_edge),
        .len      ((state_q == ST_DEATH) ? DEATH_FRAMES : CLEAR_FRAMES),
        .done     (delay_done)
    );

    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        homes_d       = homes_q;
        level_d       = level_q;
        score_d       = score_q;
        timer_reset_d = 1'b0;
        dead_d        = 1'b0;

        case (state_q)
            ST_TITLE: begin
                if (start_edge) begin
                    state_d       = ST_PLAY;
                    lives_d       = 2'(START_LIVES);
                    homes_d       = '0;
                    level_d       = LEVEL_W'(1);
                    score_d       = '0;
                    timer_reset_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // A home reached in the same cycle as a death never counts.
                if (frog_hit || time_out) begin
                    state_d = ST_DEATH;
                end else if (frog_home) begin
                    homes_d       = homes_inc;
                    score_d       = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    timer_reset_d = 1'b1;
                    if (homes_inc == 3'(HOMES_TO_CLEAR)) begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_DEATH: begin
                if (delay_done) begin
                    dead_d  = 1'b1;
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    state_d = (lives_q <= 2'd1) ? ST_OVER : ST_PLAY;
                end
            end
            ST_CLEAR: begin
                if (delay_done) begin
                    state_d       = ST_PLAY;
                    homes_d       = '0;
                    level_d       = (level_q == LEVEL_MAX) ? level_q : level_q + 1'b1;
                    timer_reset_d = 1'b1;
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    state_d = ST_TITLE;
                end
            end
            default: state_d = ST_TITLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_TITLE;
            lives_q       <= '0;
            homes_q       <= '0;
            level_q       <= LEVEL_W'(1);
            score_q       <= '0;
            timer_reset_q <= 1'b0;
            dead_q        <= 1'b0;
            start_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            homes_q       <= homes_d;
            level_q       <= level_d;
            score_q       <= score_d;
            timer_reset_q <= timer_reset_d;
            dead_q        <= dead_d;
            start_prev_q  <= start_key;
        end
    end

    assign GameState       = to_game_state(state_q);
    assign TimerReset      = timer_reset_q;
    assign is_dead_delayed = dead_q;
    assign frog_freeze     = (state_q != ST_PLAY);
    assign Lives           = lives_q;
    assign HomesFilled     = homes_q;
    assign Level           = level_q;
    assign Score           = score_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random play, all checked
// each cycle against a countdown-style behavioural model of the round rules.
module tb_game_flow_ctrl;

    localparam int START = 3;
    localparam int HOMES = 5;
    localparam int DF    = 90;
    localparam int CF    = 120;
    localparam int HP    = 50;

    localparam int M_TITLE = 0;
    localparam int M_PLAY  = 1;
    localparam int M_DYING = 2;
    localparam int M_CLEAR = 3;
    localparam int M_OVER  = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame = 1'b0;
    logic        start_key = 1'b0;
    logic        frog_hit = 1'b0;
    logic        frog_home = 1'b0;
    logic [7:0]  TimeLeft = 8'd100;
    logic [1:0]  GameState;
    logic        TimerReset;
    logic        is_dead_delayed;
    logic        frog_freeze;
    logic [1:0]  Lives;
    logic [2:0]  HomesFilled;
    logic [3:0]  Level;
    logic [15:0] Score;

    always #5 Clk = ~Clk;

    game_flow_ctrl dut (
        .Clk                   (Clk),
        .Reset                 (Reset),
        .frame_clk_rising_edge (frame),
        .start_key             (start_key),
        .frog_hit              (frog_hit),
        .frog_home             (frog_home),
        .TimeLeft              (TimeLeft),
        .GameState             (GameState),
        .TimerReset            (TimerReset),
        .is_dead_delayed       (is_dead_delayed),
        .frog_freeze           (frog_freeze),
        .Lives                 (Lives),
        .HomesFilled           (HomesFilled),
        .Level                 (Level),
        .Score                 (Score)
    );

    // Behavioural model: the round as a mode plus frames still to wait.
    int m_mode, m_lives, m_homes, m_level, m_score, m_frames;
    bit m_tr, m_dd, m_prev_key, m_edge, m_timeout, n_tr, n_dd;

    function automatic int gs_of(input int mode);
        case (mode)
            M_PLAY, M_DYING: return 1;
            M_CLEAR:         return 3;
            M_OVER:          return 2;
            default:         return 0;
        endcase
    endfunction

    always @(posedge Clk) begin
        m_edge    = start_key && !m_prev_key;
        m_timeout = (TimeLeft == 8'd0) && !m_tr;
        m_prev_key = Reset ? 1'b0 : start_key;
        n_tr = 1'b0;
        n_dd = 1'b0;
        if (Reset) begin
            m_mode  = M_TITLE;
            m_lives = 0;
            m_homes = 0;
            m_level = 1;
            m_score = 0;
        end else begin
            case (m_mode)
                M_TITLE: if (m_edge) begin
                    m_mode = M_PLAY; m_lives = START; m_homes = 0;
                    m_level = 1; m_score = 0; n_tr = 1'b1;
                end
                M_PLAY: begin
                    if (frog_hit || m_timeout) begin
                        m_mode = M_DYING; m_frames = DF;
                    end else if (frog_home) begin
                        m_homes = m_homes + 1;
                        m_score = m_score + HP + int'(TimeLeft);
                        if (m_score > 65535) m_score = 65535;
                        n_tr = 1'b1;
                        if (m_homes == HOMES) begin
                            m_mode = M_CLEAR; m_frames = CF;
                        end
                    end
                end
                M_DYING: if (frame) begin
                    m_frames = m_frames - 1;
                    if (m_frames == 0) begin
                        n_dd = 1'b1;
                        m_mode = (m_lives <= 1) ? M_OVER : M_PLAY;
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    end
                end
                M_CLEAR: if (frame) begin
                    m_frames = m_frames - 1;
                    if (m_frames == 0) begin
                        m_mode = M_PLAY; m_homes = 0; n_tr = 1'b1;
                        m_level = (m_level < 15) ? m_level + 1 : 15;
                    end
                end
                default: if (m_edge) m_mode = M_TITLE;
            endcase
        end
        m_tr = n_tr;
        m_dd = n_dd;
    end

    int tests = 0;
    int fails = 0;
    int tr_seen = 0;
    int dd_seen = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
        #1;
    endtask

    task automatic frames(input int n);
        frame = 1'b1;
        repeat (n) cyc();
        frame = 1'b0;
    endtask

    int tr0, dd0, s0, n;

    initial begin
        fork
            forever begin
                @(negedge Clk);
                if (chk_en) begin
                    cmp("GameState", int'(GameState), gs_of(m_mode));
                    cmp("TimerReset", int'(TimerReset), int'(m_tr));
                    cmp("is_dead_delayed", int'(is_dead_delayed), int'(m_dd));
                    cmp("frog_freeze", int'(frog_freeze), (m_mode == M_PLAY) ? 0 : 1);
                    cmp("Lives", int'(Lives), m_lives);
                    cmp("HomesFilled", int'(HomesFilled), m_homes);
                    cmp("Level", int'(Level), m_level);
                    cmp("Score", int'(Score), m_score);
                    cmp("pulse_overlap", int'(TimerReset && is_dead_delayed), 0);
                    if (TimerReset) tr_seen++;
                    if (is_dead_delayed) dd_seen++;
                end
            end
        join_none

        // Reset state
        @(posedge Clk);
        #1 chk_en = 1'b1;
        repeat (2) cyc();
        Reset = 1'b0;
        cmp("rst_gamestate", int'(GameState), 0);
        cmp("rst_lives", int'(Lives), 0);
        cmp("rst_level", int'(Level), 1);
        cmp("rst_freeze", int'(frog_freeze), 1);
        cyc();

        // Held start key: a single entry into play
        tr0 = tr_seen;
        start_key = 1'b1;
        repeat (10) cyc();
        start_key = 1'b0;
        cmp("start_tr_pulses", tr_seen - tr0, 1);
        cmp("start_gamestate", int'(GameState), 1);
        cmp("start_lives", int'(Lives), 3);

        // Homes, then a level clear
        TimeLeft = 8'd20;
        frog_home = 1'b1;
        cyc();
        frog_home = 1'b0;
        cmp("home1_score", int'(Score), 70);
        cmp("home1_homes", int'(HomesFilled), 1);
        cmp("home1_tr", int'(TimerReset), 1);
        cyc();
        cmp("home1_tr_low", int'(TimerReset), 0);
        repeat (4) begin
            frog_home = 1'b1;
            cyc();
            frog_home = 1'b0;
            cyc();
        end
        cmp("clear_gamestate", int'(GameState), 3);
        cmp("clear_score", int'(Score), 350);
        TimeLeft = 8'd100;
        frames(119);
        cmp("clear_119", int'(GameState), 3);
        frames(1);
        cmp("clear_done_gs", int'(GameState), 1);
        cmp("clear_done_level", int'(Level), 2);
        cmp("clear_done_homes", int'(HomesFilled), 0);

        // Death 1: frog_hit
        frog_hit = 1'b1;
        cyc();
        frog_hit = 1'b0;
        cmp("death1_freeze", int'(frog_freeze), 1);
        dd0 = dd_seen;
        frames(89);
        cmp("death1_89_dd", dd_seen - dd0, 0);
        cmp("death1_89_lives", int'(Lives), 3);
        frames(1);
        cmp("death1_dd", int'(is_dead_delayed), 1);
        cmp("death1_lives", int'(Lives), 2);
        cyc();
        cmp("death1_dd_once", dd_seen - dd0, 1);
        cmp("death1_play", int'(frog_freeze), 0);

        // Death 2: home in the same cycle as a hit is dropped
        s0 = int'(Score);
        frog_hit = 1'b1;
        frog_home = 1'b1;
        cyc();
        frog_hit = 1'b0;
        frog_home = 1'b0;
        cmp("hit_home_score", int'(Score), s0);
        frames(90);
        cmp("death2_lives", int'(Lives), 1);

        // Death 3: timeout, then game over
        TimeLeft = 8'd0;
        cyc();
        TimeLeft = 8'd100;
        cmp("timeout_freeze", int'(frog_freeze), 1);
        frames(90);
        cmp("over_gs", int'(GameState), 2);
        cmp("over_lives", int'(Lives), 0);
        cmp("over_score", int'(Score), s0);
        start_key = 1'b1; cyc(); start_key = 1'b0; cyc();
        cmp("over_to_title", int'(GameState), 0);
        start_key = 1'b1; cyc(); start_key = 1'b0;
        cmp("restart_lives", int'(Lives), 3);
        cmp("restart_score", int'(Score), 0);

        // Reset in the middle of a death
        frog_hit = 1'b1; cyc(); frog_hit = 1'b0;
        frames(45);
        dd0 = dd_seen;
        Reset = 1'b1; cyc(); Reset = 1'b0;
        cmp("mid_rst_gs", int'(GameState), 0);
        frames(60);
        cmp("mid_rst_no_dd", dd_seen - dd0, 0);

        // Score and level saturation
        start_key = 1'b1; cyc(); start_key = 1'b0;
        TimeLeft = 8'd255;
        n = 0;
        frame = 1'b1;
        while (Score != 16'hFFFF && n < 20000) begin
            frog_home = (n % 2 == 0);
            cyc();
            n++;
        end
        frog_home = 1'b0;
        repeat (150) cyc();
        frame = 1'b0;
        cmp("sat_score", int'(Score), 16'hFFFF);
        cmp("sat_level", int'(Level), 15);

        // Random play against the model
        repeat (4000) begin
            Reset     = ($urandom_range(399) == 0);
            frame     = ($urandom_range(1) == 0);
            frog_hit  = ($urandom_range(63) == 0);
            frog_home = ($urandom_range(7) == 0);
            if ($urandom_range(19) == 0) start_key = ~start_key;
            TimeLeft  = ($urandom_range(15) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
